// File: rtl/uart_pkg.sv
// Shared types and helpers for the round-robin UART transmit scheduler.
package uart_pkg;

    localparam int DATA_BITS_DEF = 8;

    // FSM encoding kept as plain constants so older code can compare against them.
    typedef logic [2:0] state_t;
    localparam state_t IDLE  = 3'd0;
    localparam state_t ARM   = 3'd1;
    localparam state_t START = 3'd2;
    localparam state_t DATA  = 3'd3;
    localparam state_t STOP  = 3'd4;

    // Index width that never collapses to zero bits.
    function automatic int IDX_W(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_rr_arb.sv
// Combinational round-robin pick: first set req bit at or above ptr, wrapping.
module uart_rr_arb
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]          req,
    input  logic [IDX_W(NUM_REQ)-1:0]   ptr,
    output logic                        grant_valid,
    output logic [IDX_W(NUM_REQ)-1:0]   grant_idx
);
    localparam int IW = IDX_W(NUM_REQ);

    int idx;

    // Walk offsets from far to near so the nearest requester overrides.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART tx line between NUM_REQ requesters, round-robin, one frame per grant.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = DATA_BITS_DEF,
    parameter int STOP_BITS = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           baud_tick,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
    output logic [NUM_REQ-1:0]             ack,
    output logic [IDX_W(NUM_REQ)-1:0]      active_id,
    output logic                           busy,
    output logic                           frame_done,
    output logic                           tx
);
    localparam int IW = IDX_W(NUM_REQ);
    localparam int BW = IDX_W(DATA_BITS);
    localparam int SW = IDX_W(STOP_BITS);

    state_t               state;
    logic [IW-1:0]        ptr;
    logic [DATA_BITS-1:0] shift;
    logic [BW-1:0]        bit_cnt;
    logic [SW-1:0]        stop_cnt;
    logic                 grant_valid;
    logic [IW-1:0]        grant_idx;

    uart_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
        .req         (req),
        .ptr         (ptr),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= '0;
            shift      <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= '0;
            ack        <= '0;
            active_id  <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            tx         <= 1'b1;
        end else begin
            ack        <= '0;
            frame_done <= 1'b0;
            case (state)
                // A tick coinciding with the grant is deliberately dropped; ARM waits for the next one.
                IDLE: if (grant_valid) begin
                    shift          <= req_data[grant_idx*DATA_BITS +: DATA_BITS];
                    active_id      <= grant_idx;
                    ack[grant_idx] <= 1'b1;
                    busy           <= 1'b1;
                    if (int'(grant_idx) == NUM_REQ - 1) ptr <= '0;
                    else                                ptr <= grant_idx + 1'b1;
                    state          <= ARM;
                end
                ARM: if (baud_tick) begin
                    tx    <= 1'b0;
                    state <= START;
                end
                START: if (baud_tick) begin
                    tx      <= shift[0];
                    bit_cnt <= '0;
                    state   <= DATA;
                end
                DATA: if (baud_tick) begin
                    shift <= shift >> 1;
                    if (bit_cnt < BW'(DATA_BITS - 1)) begin
                        tx      <= shift[1];
                        bit_cnt <= bit_cnt + 1'b1;
                    end else begin
                        tx       <= 1'b1;
                        stop_cnt <= '0;
                        state    <= STOP;
                    end
                end
                STOP: if (baud_tick) begin
                    if (stop_cnt == SW'(STOP_BITS - 1)) begin
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        stop_cnt <= stop_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
